muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide engine with a start/busy/done handshake and architectural HI/LO registers. Supports signed and unsigned multiply and divide at any WIDTH. Sits beside the single-cycle ALU datapath, which reads HI/LO for move-from-HI/LO operations. Replaces the fixed 32-bit unsigned-only multicycle MULTU/DIVU path.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits (even, >= 4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
dataA  in  WIDTH  multiplicand / dividend; sampled with start
dataB  in  WIDTH  multiplier / divisor; sampled with start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse: HI/LO are updated and valid
div_by_zero  out  1  valid with done; 1 for a DIV/DIVU with dataB == 0
hi  out  WIDTH  MULT: upper product half; DIV: remainder
lo  out  WIDTH  MULT: lower product half; DIV: quotient

Behaviour:
- Reset (reset == 0, asynchronous): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; counter and working registers cleared. Reset mid-operation aborts with no HI/LO update.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: on start=1 at edge E0, latch op, magnitudes of operands (absolute value for signed ops, raw otherwise), result sign and remainder sign, and zero-divisor flag. Go to CALC with counter=WIDTH. busy=1 after E0.
- start while busy, or in the done cycle: ignored. No queueing.
- CALC: one iteration per cycle for exactly WIDTH cycles (E1..E_WIDTH).
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements to 0, then go to FIX.
- FIX, edge E_WIDTH+1:
  - Apply two's-complement negation where required: product if operand signs differ; quotient if signs differ; remainder takes the dividend's sign.
  - Write HI/LO.
  - Assert done for exactly one cycle, drop busy the same cycle, return to IDLE.
- Latency: done is visible WIDTH+1 cycles after the start edge (33 for WIDTH=32). A new start is accepted in the cycle after done.
- Divide by zero, either signedness: hi = dividend (original, unsigned-view bits), lo = all ones, div_by_zero=1. Same latency, no early exit.
- Signed overflow, MIN / -1: lo = MIN, hi = 0, div_by_zero=0.
- Width rules:
  - Products are the full 2*WIDTH bits, no truncation.
  - Signed MIN operands are handled as magnitude 2^(WIDTH-1) in WIDTH-bit unsigned arithmetic.
- HI/LO hold their value between operations and change only at FIX or on reset.
- div_by_zero holds its last value until the next FIX.
- op/dataA/dataB changes after E0 have no effect.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11
  - state encoding S_IDLE, S_CALC, S_FIX
  - the existing ALU function codes MFHI=6'd16, MFLO=6'd18, MULTU=6'd25, DIVU=6'd27, plus new MULT=6'd24, DIV=6'd26, so the decode feeding op stays consistent
- Sub-module: none required. An optional combinational muldiv_negate (conditional two's complement, parametrised width) is natural because it is reused for operand abs and result fixup.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done at start+33 cycles; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles before done.
- MULT -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100 / 7 -> lo=14, hi=2. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 5 / 0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1. The next MULTU 2*3 yields div_by_zero=0, lo=6, hi=0.
- start pulsed with different operands 10 cycles into a DIVU 100/7 -> ignored; result stays lo=14, hi=2. Back-to-back start the cycle after done is accepted.
- reset=0 at cycle 15 of MULTU 6*7 (HI/LO previously 2/14) -> hi=lo=0, busy=0 immediately, no done pulse. After release, a fresh MULTU 6*7 gives lo=42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide engine and the ALU
// decode that selects its operation.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    // ALU function codes; op is decoded from these upstream
    localparam logic [5:0] MFHI  = 6'd16;
    localparam logic [5:0] MFLO  = 6'd18;
    localparam logic [5:0] MULT  = 6'd24;
    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] DIV   = 6'd26;
    localparam logic [5:0] DIVU  = 6'd27;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's complement, shared by operand abs and result sign fixup.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide with
// start/busy/done handshake and architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, res_neg, rem_neg, dz;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;

    logic               accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, trial, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign busy   = (state != S_IDLE);
    assign accept = (state == S_IDLE) && start && !done;

    muldiv_negate #(.W(WIDTH)) u_abs_a (.a(dataA), .neg(op[0] & dataA[WIDTH-1]), .y(abs_a));
    muldiv_negate #(.W(WIDTH)) u_abs_b (.a(dataB), .neg(op[0] & dataB[WIDTH-1]), .y(abs_b));

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff     = trial - {1'b0, opb};
    assign div_next = diff[WIDTH]
                    ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                    : {diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    muldiv_negate #(.W(2*WIDTH)) u_fix_p (.a(acc), .neg(res_neg), .y(prod_fix));
    muldiv_negate #(.W(WIDTH))   u_fix_q (.a(acc[WIDTH-1:0]), .neg(res_neg), .y(q_fix));
    muldiv_negate #(.W(WIDTH))   u_fix_r (.a(acc[2*WIDTH-1:WIDTH]), .neg(rem_neg), .y(r_fix));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CALC;
            S_CALC:  if (cnt == CNT_W'(1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            dz          <= 1'b0;
            acc         <= '0;
            opb         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    cnt     <= CNT_W'(WIDTH);
                    is_div  <= op[1];
                    res_neg <= op[0] & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                    rem_neg <= op[0] & dataA[WIDTH-1];
                    dz      <= op[1] & (dataB == '0);
                    acc     <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                    opb     <= op[1] ? abs_b : abs_a;
                end
                S_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    acc <= is_div ? div_next : mul_next;
                end
                S_FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    if (is_div) begin
                        // a zero divisor leaves the remainder equal to the dividend
                        hi <= r_fix;
                        lo <= dz ? {WIDTH{1'b1}} : q_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table plus handshake, abort and ignore corners.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] dataA, dataB;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi, lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    vec_t vt[13];
    int   checks = 0;
    int   errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .dataA(dataA), .dataB(dataB),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.dz = d;
        return e;
    endfunction

    // poke_at: pulse a stray start at that busy cycle; abort_at: assert reset there
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input exp_t e, input int poke_at, input int abort_at);
        int   lat;
        int   busy_cnt;
        exp_t want;
        @(negedge clk);
        check("idle_before_start", {62'd0, busy, done}, 64'd0);
        start = 1'b1; op = o; dataA = a; dataB = b;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; op = ~o; dataA = $urandom; dataB = $urandom;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat <= W + 5) begin
            if (busy) busy_cnt++;
            if (lat == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_hi", hi, 0);
                check("abort_lo", lo, 0);
                check("abort_busy", busy, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                end
                reset = 1'b1;
                void'(sb.pop_back());
                return;
            end
            if (lat == poke_at) begin
                start = 1'b1; op = OP_MULTU; dataA = 32'd9; dataB = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, W + 1);
        check("busy_cycles", busy_cnt, W + 1);
        check("busy_at_done", busy, 0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            want = sb.pop_front();
            check("hi", hi, want.hi);
            check("lo", lo, want.lo);
            check("div_by_zero", div_by_zero, want.dz);
        end
    endtask

    initial begin
        vt[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vt[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vt[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vt[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[6]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vt[7]  = '{OP_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        vt[8]  = '{OP_DIV,   32'hFFFFFFEC, 32'd0,        32'hFFFFFFEC, 32'hFFFFFFFF, 1'b1};
        vt[9]  = '{OP_MULT,  32'd7,        32'hFFFFFFF7, 32'hFFFFFFFF, 32'hFFFFFFC1, 1'b0};
        vt[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vt[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 1'b0};
        vt[12] = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};

        reset = 1'b0; start = 1'b0; op = OP_MULTU; dataA = '0; dataB = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;

        // back-to-back: each run starts the cycle after the previous done
        for (int i = 0; i < 13; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, mk(vt[i].hi, vt[i].lo, vt[i].dz), -1, -1);

        // div_by_zero and HI/LO hold while idle, then clear on the next op
        run_op(OP_DIVU, 32'd5, 32'd0, mk(32'd5, 32'hFFFFFFFF, 1'b1), -1, -1);
        repeat (4) @(negedge clk);
        check("dz_hold", div_by_zero, 1);
        check("hi_hold", hi, 5);
        run_op(OP_MULTU, 32'd2, 32'd3, mk(32'd0, 32'd6, 1'b0), -1, -1);

        // start asserted during the done cycle is ignored
        run_op(OP_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), -1, -1);
        start = 1'b1; op = OP_MULTU; dataA = 32'd3; dataB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_start_ignored", busy, 0);
        check("lo_after_ignored", lo, 14);

        // stray start while busy is ignored
        run_op(OP_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0), 10, -1);

        // reset mid-operation aborts and clears HI/LO
        run_op(OP_MULTU, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0), -1, 15);
        run_op(OP_MULTU, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0), -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
